hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard controller for the five-stage MIPS core (C/D/E/M/W). It keeps its own shadow scoreboard of destination register and Tnew for the E, M and W stages, advanced in lockstep with the pipeline registers. From the D-stage operand Tuse and the MDU busy countdown it decides stall and bubble. It also drives the D-stage forwarding selects for branch/jr comparison operands. It sits beside the stage-D decoder; its outputs gate the C/D pipeline register enables and clear the D/E register.

## Interface
Parameters:
- MULT_CYCLES, 5, HI/LO busy cycles after a mult/multu issues
- DIV_CYCLES, 10, HI/LO busy cycles after a div/divu issues
- TW, 2, width of Tnew/Tuse fields

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- d_rs, d_rt  in  5  source register numbers of the instruction in D
- d_use_rs, d_use_rt  in  1  instruction in D reads rs / rt
- d_tuse_rs, d_tuse_rt  in  TW  cycles until the operand is consumed (0 = in D, 1 = in E, 2 = in M)
- d_dst  in  5  destination register of the instruction in D (0 = none)
- d_tnew  in  TW  Tnew of the instruction measured at E (0 = jal, 1 = ALU, 2 = load)
- d_md_start  in  1  instruction in D is mult/multu/div/divu
- d_md_div  in  1  qualifies d_md_start: 1 = div/divu
- d_md_use  in  1  instruction in D is any HI/LO op (mfhi/mflo/mthi/mtlo/mult*/div*)
- stall  out  1  hold PC and the C/D register
- bubble_e  out  1  load a NOP into the D/E register this edge
- fwd_rs_sel, fwd_rt_sel  out  2  D-stage forwarding source: 0 = GRF, 1 = M-stage ALU result, 2 = W write data
- md_busy  out  1  HI/LO result not yet ready

## Operation
- Shadow slots E, M, W each hold {dst[4:0], tnew[TW-1:0]}.
- Each edge:
  - E <= stall ? {0,0} : {d_dst, d_tnew}
  - M <= {E.dst, sat_dec(E.tnew)}
  - W <= {M.dst, 0}
  - sat_dec(0) = 0.
- Data hazard, per operand x in {rs, rt}. hz_x = d_use_x & d_x != 0 & ((E.dst == d_x & E.tnew > d_tuse_x) | (M.dst == d_x & M.tnew > d_tuse_x)).
- MDU hazard: hz_md = d_md_use & md_busy.
- stall = bubble_e = hz_rs | hz_rt | hz_md. The logic is purely combinational from current state and D inputs.
- Forwarding per operand x:
  - 1 if d_x != 0 & M.dst == d_x & M.tnew == 0
  - else 2 if d_x != 0 & W.dst == d_x
  - else 0
  - M has priority over W. Register 0 never forwards and never stalls.
- MDU counter cnt, width $clog2(DIV_CYCLES+1):
  - An issue is d_md_start & !stall. On issue, cnt <= d_md_div ? DIV_CYCLES : MULT_CYCLES.
  - Otherwise, if cnt != 0, cnt <= cnt - 1.
  - md_busy = cnt != 0.
  - A stalled md_start does not load.
  - An issue while cnt != 0 cannot occur, because the instruction would be stalled by hz_md.

## Timing
- Reset values:
  - All shadow slots are {0,0} and cnt is 0.
  - Therefore stall = bubble_e = 0 and md_busy = 0.
  - fwd selects are 0 unless combinationally matched by d_* inputs (impossible with slots at 0 and d_x != 0).
- Reset asserted mid-operation clears cnt and all slots asynchronously. md_busy and stall drop in the same cycle.
- Stall decision latency: 0 cycles (same cycle as the instruction sits in D).
- Scoreboard update: 1 edge.
- MDU: after issue edge k, md_busy is high for exactly N cycles (k+1 … k+N) and falls at edge k+N.
- Simultaneous stall sources are ORed. The stall holds until all of them clear.

## Structure
- Package hazard_pkg contains:
  - FWD_GRF, FWD_M, FWD_W encodings
  - TNEW_JAL, TNEW_ALU, TNEW_LOAD constants
  - TUSE_D, TUSE_E, TUSE_M constants
  - default MULT/DIV latencies
- Sub-module md_busy_counter holds the loadable down-counter with busy flag. Its ports are clk, reset, load, is_div, busy.

## Test plan
- lw $1 in D, then add $2,$1,$3 (tuse_rs = 1) → stall = 1 for exactly 1 cycle. Next cycle stall = 0 and fwd_rs_sel = 0.
- lw $1, then beq $1,$0 (tuse 0) → stall for 2 cycles. On the third cycle stall = 0 and fwd_rs_sel = 2.
- addu $1, then beq $1,$1 → stall 1 cycle. Then fwd_rs_sel = fwd_rt_sel = 1 with stall = 0.
- mult issued, then mflo in D → md_busy and stall high for exactly 5 cycles. div issued → 10 cycles.
- div issued, reset pulsed when cnt = 3 → md_busy = 0 and stall = 0 within the same cycle. After release, slots hold {0,0}.
- Instruction writing $0 (tnew 2) followed by a reader of $0 → stall = 0 and fwd selects = 0 throughout.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared encodings for the D-stage hazard controller: forwarding selects,
// Tnew/Tuse meanings and default HI/LO unit latencies.
package hazard_pkg;
   localparam logic [1:0] FWD_GRF   = 2'd0;
   localparam logic [1:0] FWD_M     = 2'd1;
   localparam logic [1:0] FWD_W     = 2'd2;

   localparam logic [1:0] TNEW_JAL  = 2'd0;
   localparam logic [1:0] TNEW_ALU  = 2'd1;
   localparam logic [1:0] TNEW_LOAD = 2'd2;

   localparam logic [1:0] TUSE_D    = 2'd0;
   localparam logic [1:0] TUSE_E    = 2'd1;
   localparam logic [1:0] TUSE_M    = 2'd2;

   localparam int DEF_MULT_CYCLES = 5;
   localparam int DEF_DIV_CYCLES  = 10;
endpackage

// File: rtl/md_busy_counter.sv
// HI/LO busy countdown: loads the mult/div latency on issue, busy while non-zero.
// Busy rises the edge after load; no backpressure of its own.
module md_busy_counter
   import hazard_pkg::*;
#(
   parameter int MULT_CYCLES = DEF_MULT_CYCLES,
   parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
   input  logic clk,
   input  logic reset,
   input  logic load,
   input  logic is_div,
   output logic busy
);
   localparam int MAXC = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
   localparam int CW   = $clog2(MAXC + 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         cnt <= '0;
      else if (load)
         cnt <= is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
      else if (cnt != '0)
         cnt <= cnt - CW'(1);
   end

   assign busy = (cnt != '0);
endmodule

// File: rtl/hazard_ctrl.sv
// D-stage stall/bubble and branch-operand forwarding from a shadow E/M/W scoreboard.
// Decision is combinational (0 cycles); scoreboard and MDU counter update on each edge.
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int MULT_CYCLES = DEF_MULT_CYCLES,
   parameter int DIV_CYCLES  = DEF_DIV_CYCLES,
   parameter int TW          = 2
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [4:0]    d_rs,
   input  logic [4:0]    d_rt,
   input  logic          d_use_rs,
   input  logic          d_use_rt,
   input  logic [TW-1:0] d_tuse_rs,
   input  logic [TW-1:0] d_tuse_rt,
   input  logic [4:0]    d_dst,
   input  logic [TW-1:0] d_tnew,
   input  logic          d_md_start,
   input  logic          d_md_div,
   input  logic          d_md_use,
   output logic          stall,
   output logic          bubble_e,
   output logic [1:0]    fwd_rs_sel,
   output logic [1:0]    fwd_rt_sel,
   output logic          md_busy
);
   logic [4:0]    e_dst, m_dst, w_dst;
   logic [TW-1:0] e_tnew, m_tnew;
   logic          hz_rs, hz_rt, hz_md;

   function automatic logic operand_hazard(input logic use_op, input logic [4:0] r,
                                           input logic [TW-1:0] tuse,
                                           input logic [4:0] ed, input logic [TW-1:0] et,
                                           input logic [4:0] md, input logic [TW-1:0] mt);
      return use_op && (r != 5'd0) &&
             (((ed == r) && (et > tuse)) || ((md == r) && (mt > tuse)));
   endfunction

   // M wins over W: it holds the younger write to the same register.
   function automatic logic [1:0] fwd_pick(input logic [4:0] r,
                                           input logic [4:0] md, input logic [TW-1:0] mt,
                                           input logic [4:0] wd);
      if (r != 5'd0 && md == r && mt == '0)
         return FWD_M;
      else if (r != 5'd0 && wd == r)
         return FWD_W;
      return FWD_GRF;
   endfunction

   always_comb begin
      hz_rs = operand_hazard(d_use_rs, d_rs, d_tuse_rs, e_dst, e_tnew, m_dst, m_tnew);
      hz_rt = operand_hazard(d_use_rt, d_rt, d_tuse_rt, e_dst, e_tnew, m_dst, m_tnew);
      hz_md = d_md_use & md_busy;
      fwd_rs_sel = fwd_pick(d_rs, m_dst, m_tnew, w_dst);
      fwd_rt_sel = fwd_pick(d_rt, m_dst, m_tnew, w_dst);
   end

   assign stall    = hz_rs | hz_rt | hz_md;
   assign bubble_e = stall;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         e_dst  <= '0;
         e_tnew <= '0;
         m_dst  <= '0;
         m_tnew <= '0;
         w_dst  <= '0;
      end else begin
         e_dst  <= stall ? 5'd0 : d_dst;
         e_tnew <= stall ? '0 : d_tnew;
         m_dst  <= e_dst;
         m_tnew <= (e_tnew != '0) ? e_tnew - TW'(1) : '0;
         w_dst  <= m_dst;
      end
   end

   md_busy_counter #(
      .MULT_CYCLES(MULT_CYCLES),
      .DIV_CYCLES (DIV_CYCLES)
   ) u_md_cnt (
      .clk   (clk),
      .reset (reset),
      .load  (d_md_start & ~stall),
      .is_div(d_md_div),
      .busy  (md_busy)
   );
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed hazard scenarios plus random traffic against an age-based pipeline model.
module tb_hazard_ctrl;
   logic       clk = 1'b0;
   logic       reset;
   logic [4:0] d_rs, d_rt, d_dst;
   logic       d_use_rs, d_use_rt, d_md_start, d_md_div, d_md_use;
   logic [1:0] d_tuse_rs, d_tuse_rt, d_tnew;
   logic       stall, bubble_e, md_busy;
   logic [1:0] fwd_rs_sel, fwd_rt_sel;

   always #5 clk = ~clk;

   hazard_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10), .TW(2)) dut (
      .clk(clk), .reset(reset),
      .d_rs(d_rs), .d_rt(d_rt), .d_use_rs(d_use_rs), .d_use_rt(d_use_rt),
      .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt), .d_dst(d_dst), .d_tnew(d_tnew),
      .d_md_start(d_md_start), .d_md_div(d_md_div), .d_md_use(d_md_use),
      .stall(stall), .bubble_e(bubble_e), .fwd_rs_sel(fwd_rs_sel),
      .fwd_rt_sel(fwd_rt_sel), .md_busy(md_busy)
   );

   int tests = 0;
   int fails = 0;

   // Instructions that left D, youngest first: index = cycles since entering E.
   typedef struct {
      int dst;
      int tnew;
   } ent_t;
   ent_t hist[$];
   int   cyc = 0;
   int   busy_until = -1;

   task automatic model_reset();
      ent_t z;
      z.dst  = 0;
      z.tnew = 0;
      hist = {};
      for (int i = 0; i < 3; i++) hist.push_back(z);
      busy_until = -1;
   endtask

   function automatic int remaining(int age);
      return (hist[age].tnew > age) ? hist[age].tnew - age : 0;
   endfunction

   function automatic int m_hz(int use_op, int r, int tuse);
      if (use_op == 0 || r == 0) return 0;
      for (int a = 0; a < 2; a++)
         if (hist[a].dst == r && remaining(a) > tuse) return 1;
      return 0;
   endfunction

   function automatic int m_fwd(int r);
      if (r == 0) return 0;
      if (hist[1].dst == r && remaining(1) == 0) return 1;
      if (hist[2].dst == r) return 2;
      return 0;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic drive(input int rs, rt, urs, urt, trs, trt, dst, tn, ms, mdv, mu);
      d_rs = 5'(rs);       d_rt = 5'(rt);
      d_use_rs = 1'(urs);  d_use_rt = 1'(urt);
      d_tuse_rs = 2'(trs); d_tuse_rt = 2'(trt);
      d_dst = 5'(dst);     d_tnew = 2'(tn);
      d_md_start = 1'(ms); d_md_div = 1'(mdv); d_md_use = 1'(mu);
   endtask

   // One D-stage cycle: drive, check against model (and optional directed constants), clock.
   task automatic step(input int rs, rt, urs, urt, trs, trt, dst, tn, ms, mdv, mu,
                       input int xs = -1, input int xfr = -1, input int xft = -1,
                       input int xb = -1);
      int e_busy, e_st;
      ent_t e;
      drive(rs, rt, urs, urt, trs, trt, dst, tn, ms, mdv, mu);
      #1;
      e_busy = (cyc <= busy_until) ? 1 : 0;
      e_st   = (m_hz(urs, rs, trs) | m_hz(urt, rt, trt) | (mu & e_busy)) != 0 ? 1 : 0;
      chk("stall", stall, e_st);
      chk("bubble_e", bubble_e, e_st);
      chk("fwd_rs_sel", fwd_rs_sel, m_fwd(rs));
      chk("fwd_rt_sel", fwd_rt_sel, m_fwd(rt));
      chk("md_busy", md_busy, e_busy);
      if (xs >= 0)  chk("dir_stall", stall, xs);
      if (xfr >= 0) chk("dir_fwd_rs", fwd_rs_sel, xfr);
      if (xft >= 0) chk("dir_fwd_rt", fwd_rt_sel, xft);
      if (xb >= 0)  chk("dir_md_busy", md_busy, xb);
      @(posedge clk);
      e.dst  = e_st ? 0 : dst;
      e.tnew = e_st ? 0 : tn;
      hist.push_front(e);
      void'(hist.pop_back());
      if (ms != 0 && e_st == 0) busy_until = cyc + (mdv != 0 ? 10 : 5);
      cyc++;
      #1;
   endtask

   task automatic nop(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      drive(1, 2, 1, 1, 0, 0, 0, 0, 0, 0, 1);
      model_reset();
      #12;
      chk("rst_stall", stall, 0);
      chk("rst_bubble", bubble_e, 0);
      chk("rst_md_busy", md_busy, 0);
      chk("rst_fwd_rs", fwd_rs_sel, 0);
      chk("rst_fwd_rt", fwd_rt_sel, 0);
      @(posedge clk);
      #1 reset = 1'b0;

      // lw $1 ; add $2,$1,$3 (tuse 1): one stall, then GRF
      step(0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0);
      step(1, 3, 1, 1, 1, 1, 2, 1, 0, 0, 0, 1);
      step(1, 3, 1, 1, 1, 1, 2, 1, 0, 0, 0, 0, 0);
      nop(3);

      // lw $1 ; beq $1,$0 (tuse 0): two stalls, then W forward
      step(0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0);
      step(1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1);
      step(1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1);
      step(1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0);
      nop(3);

      // addu $1 ; beq $1,$1: one stall, then both operands from M
      step(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
      step(1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1);
      step(1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
      nop(3);

      // mult then mflo: five busy/stall cycles
      step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, -1, -1, 0);
      for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 0, 4, 1, 0, 0, 1, 1, -1, -1, 1);
      step(0, 0, 0, 0, 0, 0, 4, 1, 0, 0, 1, 0, -1, -1, 0);
      nop(3);

      // div then mflo: ten busy/stall cycles
      step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0);
      for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 0, 0, 4, 1, 0, 0, 1, 1, -1, -1, 1);
      step(0, 0, 0, 0, 0, 0, 4, 1, 0, 0, 1, 0, -1, -1, 0);
      nop(3);

      // div, lw $5 in flight, reset while the counter reads 3
      step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0);
      nop(6);
      step(0, 0, 0, 0, 0, 0, 5, 2, 0, 0, 0, -1, -1, -1, 1);
      drive(5, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1);
      #1;
      chk("pre_rst_md_busy", md_busy, 1);
      chk("pre_rst_stall", stall, 1);
      #1 reset = 1'b1;
      #1;
      chk("mid_rst_md_busy", md_busy, 0);
      chk("mid_rst_stall", stall, 0);
      chk("mid_rst_bubble", bubble_e, 0);
      @(posedge clk);
      cyc++;
      model_reset();
      #1 reset = 1'b0;
      step(5, 5, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
      step(5, 5, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

      // writer of $0 (tnew 2) then readers of $0
      step(0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) step(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

      // random traffic over a small register set to provoke overlaps
      for (int i = 0; i < 400; i++) begin
         int ms, mu;
         ms = ($urandom_range(0, 7) == 0) ? 1 : 0;
         mu = (ms != 0 || $urandom_range(0, 5) == 0) ? 1 : 0;
         step($urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 1), $urandom_range(0, 1),
              $urandom_range(0, 2), $urandom_range(0, 2),
              $urandom_range(0, 3), $urandom_range(0, 2),
              ms, $urandom_range(0, 1), mu);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
